// File: rtl/serial_bit_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_feeder_if
//  Description : Word handshake and serial-output bundle for serial_bit_feeder.
//                The master side supplies words and observes the serial stream.
//                The slave side is the feeder itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_bit_feeder_if #(
    parameter int WIDTH = 6
) ();
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             x_out;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, x_out, x_valid, word_done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, x_out, x_valid, word_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_feeder
//  Description : Parallel-to-serial stage feeding the "110101" sequence
//                detector. Accepts WIDTH-bit words on valid/ready and emits
//                one bit per clock on x_out, holding IDLE_BIT between words.
//                Optional macro SER_PARITY_EN appends an even-parity bit
//                after the data bits of every word.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int   WIDTH     = 6,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serial_bit_feeder_if.slave bus
);

`ifdef SER_PARITY_EN
    localparam int c_NBITS = WIDTH + 1;
`else
    localparam int c_NBITS = WIDTH;
`endif
    localparam int c_CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_NBITS-1:0] r_shift;
    logic [c_NBITS-1:0] w_shift_nxt;
    logic [c_NBITS-1:0] w_load;
    logic [c_CW-1:0]    r_cnt;
    logic [c_CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0]   w_ordered;
    logic               w_last;
    logic               w_xfer;
    logic               w_x_valid_nxt;
    logic               w_x_out_nxt;
    logic               w_word_done_nxt;
    logic               r_x_out;
    logic               r_x_valid;
    logic               r_word_done;
    logic               r_busy;

    // Arrange the word so the first bit to transmit sits at the top.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_ordered = bus.data_in;
        end else begin : g_lsb_first
            for (genvar i = 0; i < WIDTH; i++) begin : g_rev
                assign w_ordered[i] = bus.data_in[WIDTH-1-i];
            end
        end
    endgenerate

`ifdef SER_PARITY_EN
    assign w_load = {w_ordered, ^bus.data_in};
`else
    assign w_load = w_ordered;
`endif

    // The last bit cycle can accept the next word so back-to-back words have no bubble.
    assign w_last          = (r_state == S_SHIFT) && (r_cnt == '0);
    assign bus.data_ready  = (r_state == S_IDLE) || w_last;
    assign w_xfer          = bus.data_valid && bus.data_ready;

    // Next-state, shifter and registered-output precomputation.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        if (r_state == S_IDLE) begin
            if (w_xfer) begin
                w_shift_nxt = w_load;
                w_cnt_nxt   = c_CW'(c_NBITS - 1);
                w_state_nxt = S_SHIFT;
            end
        end else begin
            if (r_cnt == '0) begin
                if (w_xfer) begin
                    w_shift_nxt = w_load;
                    w_cnt_nxt   = c_CW'(c_NBITS - 1);
                end else begin
                    w_shift_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_shift_nxt = r_shift << 1;
                w_cnt_nxt   = r_cnt - 1'b1;
            end
        end
        w_x_valid_nxt   = (w_state_nxt == S_SHIFT);
        w_x_out_nxt     = w_x_valid_nxt ? w_shift_nxt[c_NBITS-1] : IDLE_BIT;
        w_word_done_nxt = w_x_valid_nxt && (w_cnt_nxt == '0);
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_x_out     <= IDLE_BIT;
            r_x_valid   <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_x_out     <= w_x_out_nxt;
            r_x_valid   <= w_x_valid_nxt;
            r_word_done <= w_word_done_nxt;
            r_busy      <= w_x_valid_nxt;
        end
    end

    assign bus.x_out     = r_x_out;
    assign bus.x_valid   = r_x_valid;
    assign bus.word_done = r_word_done;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_bit_feeder
//  Description : Bench for serial_bit_feeder. Two instances (MSB-first and
//                LSB-first) share stimulus; a queue-of-bits model predicts
//                every output each cycle, plus literal checks of key cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_bit_feeder;
    localparam int W = 6;
`ifdef SER_PARITY_EN
    localparam int N = W + 1;
    localparam logic [6:0] c_EXP_MSB = 7'b1101010;
    localparam logic [6:0] c_EXP_LSB = 7'b1010110;
`else
    localparam int N = W;
    localparam logic [6:0] c_EXP_MSB = 7'b0110101;
    localparam logic [6:0] c_EXP_LSB = 7'b0101011;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    serial_bit_feeder_if #(.WIDTH(W)) bus0 ();
    serial_bit_feeder_if #(.WIDTH(W)) bus1 ();

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Model: bits still to appear on x_out, head = bit shown this cycle.
    bit mq0[$];
    bit mq1[$];

    // Last sampled DUT values for literal checks.
    logic s_xo0, s_xo1, s_xv, s_wd, s_rdy, s_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against model, advance model at the edge.
    task automatic step(input logic rst_v, input logic v, input logic [W-1:0] d);
        logic erdy;
        reset           = rst_v;
        bus0.data_valid = v;
        bus0.data_in    = d;
        bus1.data_valid = v;
        bus1.data_in    = d;
        @(negedge clk);
        erdy = (mq0.size() <= 1);
        chk("x_valid0",   bus0.x_valid,   32'(mq0.size() > 0));
        chk("x_out0",     bus0.x_out,     32'((mq0.size() > 0) ? mq0[0] : 1'b0));
        chk("word_done0", bus0.word_done, 32'(mq0.size() == 1));
        chk("busy0",      bus0.busy,      32'(mq0.size() > 0));
        chk("ready0",     bus0.data_ready, 32'(erdy));
        chk("x_valid1",   bus1.x_valid,   32'(mq1.size() > 0));
        chk("x_out1",     bus1.x_out,     32'((mq1.size() > 0) ? mq1[0] : 1'b0));
        chk("word_done1", bus1.word_done, 32'(mq1.size() == 1));
        chk("ready1",     bus1.data_ready, 32'(mq1.size() <= 1));
        s_xo0  = bus0.x_out;
        s_xo1  = bus1.x_out;
        s_xv   = bus0.x_valid;
        s_wd   = bus0.word_done;
        s_rdy  = bus0.data_ready;
        s_busy = bus0.busy;
        @(posedge clk);
        if (rst_v) begin
            mq0.delete();
            mq1.delete();
        end else begin
            if (mq0.size() > 0) void'(mq0.pop_front());
            if (mq1.size() > 0) void'(mq1.pop_front());
            if (v && erdy) begin
                for (int i = 0; i < W; i++) begin
                    mq0.push_back(d[W-1-i]);
                    mq1.push_back(d[i]);
                end
`ifdef SER_PARITY_EN
                mq0.push_back(^d);
                mq1.push_back(^d);
`endif
            end
        end
        #1;
    endtask

    initial begin
        logic [6:0] e0;
        logic [6:0] e1;
        e0 = c_EXP_MSB;
        e1 = c_EXP_LSB;
        bus0.data_valid = 1'b0; bus0.data_in = '0;
        bus1.data_valid = 1'b0; bus1.data_in = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Idle after reset: defined level, ready, not busy.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, '0);
            chk("idle_xo",   s_xo0, 0);
            chk("idle_xv",   s_xv, 0);
            chk("idle_busy", s_busy, 0);
            chk("idle_rdy",  s_rdy, 1);
        end

        // Single word, both bit orders.
        step(1'b0, 1'b1, 6'b110101);
        for (int k = 0; k < N; k++) begin
            step(1'b0, 1'b0, '0);
            chk("w1_bit_msb", s_xo0, 32'(e0[N-1-k]));
            chk("w1_bit_lsb", s_xo1, 32'(e1[N-1-k]));
            chk("w1_xv",      s_xv, 1);
            chk("w1_done",    s_wd, 32'(k == N-1));
        end
        step(1'b0, 1'b0, '0);
        chk("w1_after_xv", s_xv, 0);
        chk("w1_after_xo", s_xo0, 0);

        // Two words with valid held: continuous stream, ready only at boundaries.
        step(1'b0, 1'b1, 6'b110101);
        for (int k = 1; k <= 2*N; k++) begin
            step(1'b0, (k <= N), 6'b110101);
            chk("b2b_xv",   s_xv, 1);
            chk("b2b_bit",  s_xo0, 32'(e0[N-1-((k-1) % N)]));
            chk("b2b_done", s_wd,  32'(k == N || k == 2*N));
            chk("b2b_rdy",  s_rdy, 32'(k == N || k == 2*N));
        end
        step(1'b0, 1'b0, '0);
        chk("b2b_end_xv", s_xv, 0);

        // Reset after the third bit discards the word.
        step(1'b0, 1'b1, 6'b111111);
        for (int k = 1; k <= 3; k++) begin
            step((k == 3), 1'b0, '0);
            chk("rst_bit",  s_xo0, 1);
            chk("rst_done", s_wd, 0);
        end
        step(1'b0, 1'b0, '0);
        chk("rst_xo",   s_xo0, 0);
        chk("rst_xv",   s_xv, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_rdy",  s_rdy, 1);
        chk("rst_done2", s_wd, 0);

`ifdef SER_PARITY_EN
        // Odd-weight word gives a parity bit of 1.
        step(1'b0, 1'b1, 6'b110100);
        for (int k = 0; k < N; k++) step(1'b0, 1'b0, '0);
        chk("par_bit", s_xo0, 1);
        chk("par_done", s_wd, 1);
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), W'($urandom));
        end
        for (int k = 0; k < N + 2; k++) step(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
